// File: rtl/stage_if.sv
// Instruction-fetch stage: holds the fetch PC, issues one outstanding imem request, offers word+PC to decode.
// Latency: zero-wait memory delivers the word combinationally in the ack cycle, giving one instruction per cycle.
// Backpressure: stall parks an acked word in instBuf (HAVE); ifBusy flags pending fetches. IF_ADEL_EN enables address-error trapping.
module stage_if #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] excVector,
  input  logic [31:0] nextPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] PC,
  output logic [31:0] instOut,
  output logic        instValid,
  output logic        ifBusy,
  output logic        adel
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HAVE = 2'd1,
    DROP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] addrReg;
  logic [31:0] instBuf;
  logic        addr_load;
  logic        buf_load;

  // Misalignment of each candidate next-pc source; only meaningful when trapping is built in.
  logic        exc_mis;
  logic        npc_mis;
  logic        pc_mis;
  state_t      tgt_exc;
  state_t      tgt_npc;

`ifdef IF_ADEL_EN
  assign exc_mis = |excVector[1:0];
  assign npc_mis = |nextPC[1:0];
  assign pc_mis  = |pc[1:0];
`else
  assign exc_mis = 1'b0;
  assign npc_mis = 1'b0;
  assign pc_mis  = 1'b0;
`endif

  assign tgt_exc = exc_mis ? ERR : REQ;
  assign tgt_npc = npc_mis ? ERR : REQ;

  // Next-state, next-pc and per-state output decode.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_load = 1'b0;
    buf_load  = 1'b0;
    imemReq   = 1'b0;
    instOut   = 32'h0;
    ifBusy    = 1'b0;
    case (state)
      REQ: begin
        imemReq = 1'b1;
        if (imemAck) begin
          // The acked word is presented even on flush; decode is flushed so it is ignored.
          instOut = imemData;
          if (flush) begin
            pc_nxt    = excVector;
            state_nxt = tgt_exc;
            addr_load = 1'b1;
          end else if (!stall) begin
            pc_nxt    = nextPC;
            state_nxt = tgt_npc;
            addr_load = 1'b1;
          end else begin
            buf_load  = 1'b1;
            state_nxt = HAVE;
          end
        end else begin
          ifBusy = 1'b1;
          // The request already on the bus must still be drained, so addrReg keeps the stale address.
          if (flush) begin
            pc_nxt    = excVector;
            state_nxt = DROP;
          end
        end
      end
      HAVE: begin
        instOut = instBuf;
        if (flush) begin
          pc_nxt    = excVector;
          state_nxt = tgt_exc;
          addr_load = 1'b1;
        end else if (!stall) begin
          pc_nxt    = nextPC;
          state_nxt = tgt_npc;
          addr_load = 1'b1;
        end
      end
      DROP: begin
        imemReq = 1'b1;
        ifBusy  = 1'b1;
        if (flush) begin
          pc_nxt = excVector;
        end
        if (imemAck) begin
          addr_load = 1'b1;
          if (flush) begin
            state_nxt = tgt_exc;
          end else begin
            state_nxt = pc_mis ? ERR : REQ;
          end
        end
      end
`ifdef IF_ADEL_EN
      ERR: begin
        // Parked on a bad address until the exception logic redirects us.
        if (flush) begin
          pc_nxt    = excVector;
          state_nxt = tgt_exc;
          addr_load = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = REQ;
      end
    endcase
  end

  // State register with asynchronous reset back to the fetch-request state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch PC, bus address and skid buffer for a word acked during stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_VECTOR;
`ifdef IF_ADEL_EN
      addrReg <= RESET_VECTOR;
`else
      addrReg <= {RESET_VECTOR[31:2], 2'b00};
`endif
      instBuf <= 32'h0;
    end else begin
      pc <= pc_nxt;
      if (addr_load) begin
`ifdef IF_ADEL_EN
        addrReg <= pc_nxt;
`else
        // Without trapping, a misaligned PC simply fetches its enclosing word.
        addrReg <= {pc_nxt[31:2], 2'b00};
`endif
      end
      if (buf_load) begin
        instBuf <= imemData;
      end
    end
  end

  assign imemAddr  = addrReg;
  assign PC        = pc;
  assign instValid = ~ifBusy;

`ifdef IF_ADEL_EN
  assign adel = (state == ERR);
`else
  assign adel = 1'b0;
`endif

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: reset, zero-wait and latency fetches, stall hold, flush redirects, misalignment, async reset.
// Inputs change just after the falling edge; outputs are checked 1ns later, well before the rising edge.
// Expected values are hand-derived constants.
module tb_stage_if;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] excVector;
  logic [31:0] nextPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] PC;
  logic [31:0] instOut;
  logic        instValid;
  logic        ifBusy;
  logic        adel;

  int n_tests = 0;
  int n_fail  = 0;

  stage_if #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .excVector(excVector), .nextPC(nextPC),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData),
    .PC(PC), .instOut(instOut), .instValid(instValid),
    .ifBusy(ifBusy), .adel(adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; excVector = 32'h0;
    nextPC = 32'h0; imemAck = 1'b0; imemData = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   imemReq,   1);
    chk("rst_valid", instValid, 0);
    chk("rst_busy",  ifBusy,    1);
    chk("rst_inst",  instOut,   0);
    chk("rst_adel",  adel,      0);
    chk("rst_pc",    PC,        32'hBFC00000);
    chk("rst_addr",  imemAddr,  32'hBFC00000);
    rst = 1'b0;

    // Zero-wait memory: one word per cycle, never busy
    for (int i = 0; i < 3; i++) begin
      imemAck  = 1'b1;
      imemData = 32'hBFC00000 + 32'(4 * i);
      nextPC   = 32'hBFC00004 + 32'(4 * i);
      #1;
      chk("zw_addr",  imemAddr,  32'hBFC00000 + 32'(4 * i));
      chk("zw_pc",    PC,        32'hBFC00000 + 32'(4 * i));
      chk("zw_inst",  instOut,   32'hBFC00000 + 32'(4 * i));
      chk("zw_valid", instValid, 1);
      chk("zw_busy",  ifBusy,    0);
      @(negedge clk);
    end

    // Latency 3: busy three cycles, then the ack cycle delivers
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 3; w++) begin
        imemAck = 1'b0; imemData = 32'h0;
        #1;
        chk("lat_busy",  ifBusy,    1);
        chk("lat_valid", instValid, 0);
        chk("lat_pc",    PC,        32'hBFC0000C + 32'(4 * f));
        @(negedge clk);
      end
      imemAck  = 1'b1;
      imemData = 32'h5A5A0000 + 32'(f);
      nextPC   = 32'hBFC00010 + 32'(4 * f);
      #1;
      chk("lat_ackbusy", ifBusy,  0);
      chk("lat_inst",    instOut, 32'h5A5A0000 + 32'(f));
      @(negedge clk);
    end

    // Ack under stall, stall held one more cycle, then released
    imemAck = 1'b1; imemData = 32'h1111AAAA; stall = 1'b1; nextPC = 32'hBFC00018;
    #1;
    chk("st_ack_inst",  instOut,   32'h1111AAAA);
    chk("st_ack_valid", instValid, 1);
    @(negedge clk);
    imemAck = 1'b0; imemData = 32'h0;
    #1;
    chk("st_have_req",  imemReq, 0);
    chk("st_have_inst", instOut, 32'h1111AAAA);
    chk("st_have_pc",   PC,      32'hBFC00014);
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("st_rel_req",  imemReq, 0);
    chk("st_rel_inst", instOut, 32'h1111AAAA);
    @(negedge clk);
    #1;
    chk("st_new_req",  imemReq,  1);
    chk("st_new_addr", imemAddr, 32'hBFC00018);
    chk("st_new_pc",   PC,       32'hBFC00018);

    // Latency 4 with flush one cycle after the request: stale ack dropped
    @(negedge clk);
    flush = 1'b1; excVector = 32'h80000180;
    #1;
    chk("fl_busy", ifBusy, 1);
    @(negedge clk);
    flush = 1'b0;
    for (int w = 0; w < 2; w++) begin
      #1;
      chk("drop_req",   imemReq,   1);
      chk("drop_addr",  imemAddr,  32'hBFC00018);
      chk("drop_pc",    PC,        32'h80000180);
      chk("drop_valid", instValid, 0);
      @(negedge clk);
    end
    imemAck = 1'b1; imemData = 32'hDEADBEEF;
    #1;
    chk("drop_ack_valid", instValid, 0);
    chk("drop_ack_busy",  ifBusy,    1);
    @(negedge clk);
    imemAck = 1'b0; imemData = 32'h0;
    for (int w = 0; w < 4; w++) begin
      #1;
      chk("redir_addr", imemAddr, 32'h80000180);
      chk("redir_busy", ifBusy,   1);
      @(negedge clk);
    end
    imemAck = 1'b1; imemData = 32'hCAFE0180; nextPC = 32'h80000184;
    #1;
    chk("redir_valid", instValid, 1);
    chk("redir_inst",  instOut,   32'hCAFE0180);
    @(negedge clk);

    // Flush together with stall while holding a word
    imemAck = 1'b1; imemData = 32'h22220184; stall = 1'b1; nextPC = 32'h80000188;
    @(negedge clk);
    imemAck = 1'b0; imemData = 32'h0; flush = 1'b1; excVector = 32'h80000200;
    #1;
    chk("fs_have_req", imemReq, 0);
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    #1;
    chk("fs_pc",   PC,       32'h80000200);
    chk("fs_req",  imemReq,  1);
    chk("fs_addr", imemAddr, 32'h80000200);
    chk("fs_busy", ifBusy,   1);

    // Simultaneous ack + flush: new fetch starts next cycle
    imemAck = 1'b1; imemData = 32'h33330200; flush = 1'b1;
    excVector = 32'h80000300; nextPC = 32'h80000204;
    @(negedge clk);
    imemAck = 1'b0; imemData = 32'h0; flush = 1'b0;
    #1;
    chk("af_pc",   PC,       32'h80000300);
    chk("af_addr", imemAddr, 32'h80000300);
    chk("af_req",  imemReq,  1);

    // Misaligned next PC
    imemAck = 1'b1; imemData = 32'h44440300; nextPC = 32'h00400002;
    @(negedge clk);
    imemAck = 1'b0; imemData = 32'h0;
    #1;
    chk("mis_pc", PC, 32'h00400002);
`ifdef IF_ADEL_EN
    chk("mis_adel",  adel,      1);
    chk("mis_valid", instValid, 1);
    chk("mis_req",   imemReq,   0);
    chk("mis_inst",  instOut,   0);
    stall = 1'b1; nextPC = 32'h00500000;
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("err_hold_pc", PC, 32'h00400002);
    flush = 1'b1; excVector = 32'h80000180;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("err_out_adel", adel,     0);
    chk("err_out_req",  imemReq,  1);
    chk("err_out_addr", imemAddr, 32'h80000180);
`else
    chk("mis_addr", imemAddr, 32'h00400000);
    chk("mis_adel", adel,     0);
    chk("mis_req",  imemReq,  1);
`endif

    // Async reset while holding a stalled word
    imemAck = 1'b1; imemData = 32'h55550000; stall = 1'b1;
    @(negedge clk);
    imemAck = 1'b0; imemData = 32'h0;
    #1;
    chk("ar_have_req", imemReq, 0);
    rst = 1'b1;
    #1;
    chk("ar_req",   imemReq,   1);
    chk("ar_pc",    PC,        32'hBFC00000);
    chk("ar_valid", instValid, 0);
    chk("ar_inst",  instOut,   0);
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
